// File: rtl/alu_sequencer.sv
// alu_sequencer: 32-bit ALU sequencer; single-cycle ops via EXEC, signed MUL/DIV via a 32-step iterative datapath.
// Build option: define ALU_SEQUENCER_DIV_EN to include the restoring divider (otherwise control 12 is illegal).
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             done,
  output logic [WIDTH-1:0] c_lo_out,
  output logic [WIDTH-1:0] c_hi_out,
  output logic             div_by_zero,
  output logic             illegal_op
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_NEG  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
`ifdef ALU_SEQUENCER_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'd12;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_LOAD = 3'd2,
    S_ITER = 3'd3,
    S_FIX  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             r_state, w_next;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH-1:0]   r_lo, r_hi;
  logic               r_done, r_dz, r_il;
  logic [4:0]         r_cnt;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               r_neg_q;

  logic               w_long;
  logic [4:0]         w_sh;
  logic [2*WIDTH-1:0] w_ror, w_rol;
  logic [WIDTH-1:0]   w_exec_lo, w_exec_hi;
  logic               w_exec_dz, w_exec_il;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

`ifdef ALU_SEQUENCER_DIV_EN
  logic               r_is_div, r_neg_r;
  logic [WIDTH:0]     w_rsh, w_diff;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;
`endif

  assign req_ready   = (r_state == S_IDLE);
  assign done        = r_done;
  assign c_lo_out    = r_lo;
  assign c_hi_out    = r_hi;
  assign div_by_zero = r_dz;
  assign illegal_op  = r_il;

  // Only MUL and a non-zero-divisor DIV take the iterative path.
`ifdef ALU_SEQUENCER_DIV_EN
  assign w_long = (control == OP_MUL) || ((control == OP_DIV) && (b_in != '0));
`else
  assign w_long = (control == OP_MUL);
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = w_long ? S_LOAD : S_EXEC;
      S_EXEC: w_next = S_DONE;
      S_LOAD: w_next = S_ITER;
      S_ITER: if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_sh  = r_b[4:0];
  assign w_ror = {r_a, r_a} >> w_sh;
  assign w_rol = {r_a, r_a} << w_sh;

  always_comb begin
    w_exec_lo = '0;
    w_exec_hi = '0;
    w_exec_dz = 1'b0;
    w_exec_il = 1'b0;
    case (r_op)
      OP_ADD:  w_exec_lo = r_a + r_b;
      OP_SUB:  w_exec_lo = r_a - r_b;
      OP_AND:  w_exec_lo = r_a & r_b;
      OP_OR:   w_exec_lo = r_a | r_b;
      OP_SHR:  w_exec_lo = r_a >> w_sh;
      OP_SHRA: w_exec_lo = $signed(r_a) >>> w_sh;
      OP_SHL:  w_exec_lo = r_a << w_sh;
      OP_ROR:  w_exec_lo = w_ror[WIDTH-1:0];
      OP_ROL:  w_exec_lo = w_rol[2*WIDTH-1:WIDTH];
      OP_NEG:  w_exec_lo = -r_a;
      OP_NOT:  w_exec_lo = ~r_a;
`ifdef ALU_SEQUENCER_DIV_EN
      // DIV reaches EXEC only with a zero divisor.
      OP_DIV: begin
        w_exec_hi = r_a;
        w_exec_dz = 1'b1;
      end
`endif
      default: w_exec_il = 1'b1;
    endcase
  end

  assign w_mag_a = r_a[WIDTH-1] ? -r_a : r_a;
  assign w_mag_b = r_b[WIDTH-1] ? -r_b : r_b;

  // Multiply step: {acc, q} holds the partial product; multiplier bits retire from q[0].
  assign w_sum      = r_acc + (r_q[0] ? {1'b0, r_d} : '0);
  assign w_prod     = {r_acc[WIDTH-1:0], r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

`ifdef ALU_SEQUENCER_DIV_EN
  // Restoring divide: acc is the partial remainder, q shifts dividend out and quotient in.
  assign w_rsh     = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_diff    = w_rsh - {1'b0, r_d};
  assign w_quo_fix = r_neg_q ? -r_q : r_q;
  assign w_rem_fix = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
`endif

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_il     <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_neg_q  <= 1'b0;
`ifdef ALU_SEQUENCER_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_op <= control;
          r_a  <= a_in;
          r_b  <= b_in;
          r_dz <= 1'b0;
          r_il <= 1'b0;
        end
        S_EXEC: begin
          r_lo   <= w_exec_lo;
          r_hi   <= w_exec_hi;
          r_dz   <= w_exec_dz;
          r_il   <= w_exec_il;
          r_done <= 1'b1;
        end
        S_LOAD: begin
          r_acc    <= '0;
          r_q      <= w_mag_a;
          r_d      <= w_mag_b;
          r_cnt    <= '0;
          r_neg_q  <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
`ifdef ALU_SEQUENCER_DIV_EN
          r_is_div <= (r_op == OP_DIV);
          r_neg_r  <= r_a[WIDTH-1];
`endif
        end
        S_ITER: begin
          r_cnt <= r_cnt + 5'd1;
`ifdef ALU_SEQUENCER_DIV_EN
          if (r_is_div) begin
            if (!w_diff[WIDTH]) begin
              r_acc <= w_diff;
              r_q   <= {r_q[WIDTH-2:0], 1'b1};
            end else begin
              r_acc <= w_rsh;
              r_q   <= {r_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_acc <= {1'b0, w_sum[WIDTH:1]};
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
`else
          r_acc <= {1'b0, w_sum[WIDTH:1]};
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
`endif
        end
        S_FIX: begin
`ifdef ALU_SEQUENCER_DIV_EN
          if (r_is_div) begin
            r_lo <= w_quo_fix;
            r_hi <= w_rem_fix;
          end else begin
            r_lo <= w_prod_fix[WIDTH-1:0];
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          end
`else
          r_lo <= w_prod_fix[WIDTH-1:0];
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
`endif
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed table, multi-cycle corner sequences, random ops vs a reference model.
module tb_alu_sequencer;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a, b, lo, hi;
    logic        dz, il;
    int          lat;
  } vec_t;

  logic        clock = 1'b0, clear = 1'b0, req_valid = 1'b0;
  logic        req_ready, done, div_by_zero, illegal_op;
  logic [3:0]  control = '0;
  logic [31:0] a_in = '0, b_in = '0, c_lo_out, c_hi_out;

  int   n_vec = 0, n_bad = 0;
  vec_t tbl[$];

  alu_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .control(control), .a_in(a_in), .b_in(b_in), .done(done),
    .c_lo_out(c_lo_out), .c_hi_out(c_hi_out),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] lo, input logic [31:0] hi,
                              input logic dz, input logic il, input int lat);
    vec_t v;
    v.ctl = c; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.dz = dz; v.il = il; v.lat = lat;
    return v;
  endfunction

  // Reference model: plain 64-bit signed arithmetic and bit-at-a-time rotation.
  function automatic vec_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    longint sa, sb, p;
    logic [31:0] r;
    v = mk(c, a, b, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    sa = $signed(a);
    sb = $signed(b);
    r  = a;
    case (c)
      4'd0:  v.lo = a + b;
      4'd1:  v.lo = a - b;
      4'd2:  v.lo = a & b;
      4'd3:  v.lo = a | b;
      4'd4:  v.lo = a >> b[4:0];
      4'd5:  v.lo = $signed(a) >>> b[4:0];
      4'd6:  v.lo = a << b[4:0];
      4'd7:  begin repeat (int'(b[4:0])) r = {r[0], r[31:1]}; v.lo = r; end
      4'd8:  begin repeat (int'(b[4:0])) r = {r[30:0], r[31]}; v.lo = r; end
      4'd9:  v.lo = 32'h0 - a;
      4'd10: v.lo = ~a;
      4'd11: begin p = sa * sb; v.lo = p[31:0]; v.hi = p[63:32]; v.lat = 34; end
`ifdef ALU_SEQUENCER_DIV_EN
      4'd12: begin
        if (b == 32'h0) begin
          v.hi = a; v.dz = 1'b1;
        end else begin
          p = sa / sb; v.lo = p[31:0];
          p = sa % sb; v.hi = p[31:0];
          v.lat = 34;
        end
      end
`endif
      default: v.il = 1'b1;
    endcase
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int n, lat;
    @(negedge clock);
    req_valid = 1'b1; control = v.ctl; a_in = v.a; b_in = v.b;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) chk("ready_timeout", 64'(n), 64'(0));
    @(posedge clock); #1;
    req_valid = 1'b0; control = 4'($urandom); a_in = $urandom; b_in = $urandom;
    lat = 0;
    while (!done && lat < 100) begin @(posedge clock); #1; lat++; end
    chk($sformatf("lat op%0d a=%h b=%h", v.ctl, v.a, v.b), 64'(lat), 64'(v.lat));
    chk($sformatf("lo op%0d a=%h b=%h", v.ctl, v.a, v.b), 64'(c_lo_out), 64'(v.lo));
    chk($sformatf("hi op%0d a=%h b=%h", v.ctl, v.a, v.b), 64'(c_hi_out), 64'(v.hi));
    chk($sformatf("dz op%0d", v.ctl), 64'(div_by_zero), 64'(v.dz));
    chk($sformatf("il op%0d", v.ctl), 64'(illegal_op), 64'(v.il));
    @(posedge clock); #1;
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("lo_hold", 64'(c_lo_out), 64'(v.lo));
  endtask

  initial begin
    int   saw;
    vec_t v;
    logic [31:0] ra, rb;

    #12;
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_lo", 64'(c_lo_out), 64'(0));
    chk("rst_hi", 64'(c_hi_out), 64'(0));
    chk("rst_flags", 64'({div_by_zero, illegal_op}), 64'(0));
    @(negedge clock); clear = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_reset", 64'(req_ready), 64'(1));

    tbl.push_back(mk(4'd0,  32'h5,        32'h7,        32'hC,        32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd1,  32'h5,        32'h7,        32'hFFFFFFFE, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd3,  32'h00FF0000, 32'h000000FF, 32'h00FF00FF, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd4,  32'h80000000, 32'h24,       32'h08000000, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd5,  32'h80000000, 32'h4,        32'hF8000000, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd6,  32'h1,        32'h1F,       32'h80000000, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd7,  32'h1,        32'h1,        32'h80000000, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd7,  32'h12345678, 32'h0,        32'h12345678, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd8,  32'h80000000, 32'h1,        32'h1,        32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd9,  32'h1,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd10, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1));
    tbl.push_back(mk(4'd11, 32'hFFFFFFFF, 32'h3,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34));
    tbl.push_back(mk(4'd11, 32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 1'b0, 1'b0, 34));
    tbl.push_back(mk(4'd11, 32'h0,        32'h5,        32'h0,        32'h0,        1'b0, 1'b0, 34));
    tbl.push_back(mk(4'd15, 32'h1234,     32'h5678,     32'h0,        32'h0,        1'b0, 1'b1, 1));
    tbl.push_back(mk(4'd13, 32'h1,        32'h1,        32'h0,        32'h0,        1'b0, 1'b1, 1));
`ifdef ALU_SEQUENCER_DIV_EN
    tbl.push_back(mk(4'd12, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34));
    tbl.push_back(mk(4'd12, 32'h9,        32'h0,        32'h0,        32'h9,        1'b1, 1'b0, 1));
    tbl.push_back(mk(4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b0, 34));
    tbl.push_back(mk(4'd12, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        1'b0, 1'b0, 34));
`else
    tbl.push_back(mk(4'd12, 32'hA,        32'h2,        32'h0,        32'h0,        1'b0, 1'b1, 1));
    tbl.push_back(mk(4'd12, 32'h9,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 1));
`endif
    foreach (tbl[i]) run_vec(tbl[i]);

    // Back-to-back with req_valid held: illegal op, then ADD accepted only after DONE.
    @(negedge clock);
    req_valid = 1'b1; control = 4'd15; a_in = 32'h1; b_in = 32'h2;
    @(posedge clock); #1;
    chk("b2b_busy_exec", 64'(req_ready), 64'(0));
    control = 4'd0;
    @(posedge clock); #1;
    chk("b2b_done1", 64'(done), 64'(1));
    chk("b2b_il1", 64'(illegal_op), 64'(1));
    chk("b2b_busy_done", 64'(req_ready), 64'(0));
    @(posedge clock); #1;
    chk("b2b_idle_ready", 64'(req_ready), 64'(1));
    chk("b2b_il_hold", 64'(illegal_op), 64'(1));
    @(posedge clock); #1;
    chk("b2b_accept2", 64'(req_ready), 64'(0));
    chk("b2b_flag_clear", 64'(illegal_op), 64'(0));
    b_in = 32'd100; req_valid = 1'b0;
    @(posedge clock); #1;
    chk("b2b_done2", 64'(done), 64'(1));
    chk("b2b_lo2", 64'(c_lo_out), 64'(3));

    // Clear pulsed in the middle of a MUL.
    run_vec(mk(4'd0, 32'h1234, 32'h0, 32'h1234, 32'h0, 1'b0, 1'b0, 1));
    @(negedge clock);
    req_valid = 1'b1; control = 4'd11; a_in = 32'hFFFFFFFF; b_in = 32'h3;
    @(posedge clock); #1; req_valid = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock); clear = 1'b0; #1;
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_lo", 64'(c_lo_out), 64'(0));
    chk("midrst_hi", 64'(c_hi_out), 64'(0));
    chk("midrst_flags", 64'({div_by_zero, illegal_op}), 64'(0));
    @(negedge clock); clear = 1'b1;
    @(posedge clock); #1;
    chk("midrst_ready", 64'(req_ready), 64'(1));
    saw = 0;
    repeat (40) begin @(posedge clock); #1; if (done) saw = 1; end
    chk("midrst_no_done", 64'(saw), 64'(0));
    run_vec(mk(4'd0, 32'h1, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 1));

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(0, 40);
        default: rb = $urandom;
      endcase
      v = model(4'($urandom_range(0, 15)), ra, rb);
      run_vec(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port clear  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-006 SHALL have port control  input  4  operation code, sampled on acceptance.
REQ-007 SHALL have ports a_in, b_in  input  32  operands, sampled on acceptance.
REQ-008 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-009 SHALL have ports c_lo_out, c_hi_out  output  32  registered LO/HI results.
REQ-010 SHALL have ports div_by_zero, illegal_op  output  1  status flags, valid with done.

Function
REQ-011 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; req_ready = 1 only in state IDLE.
REQ-012 SHALL decode control: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 MUL, 12 DIV; 13-15 illegal.
REQ-013 SHALL use shift/rotate amount b_in[4:0]; ADD/SUB wrap modulo 2^32, no carry output.
REQ-014 SHALL implement states IDLE, EXEC, LOAD, ITER, FIX, DONE.
REQ-015 SHALL transition IDLE->EXEC for ops 0-10, 13-15, and DIV with b_in = 0; IDLE->LOAD for MUL and DIV with b_in != 0.
REQ-016 SHALL, in EXEC, write result to c_lo_out, set c_hi_out = 0 (except per REQ-021), then go to DONE.
REQ-017 SHALL, in LOAD, capture operand magnitudes and result sign, clear a 5-bit iteration counter, enter ITER.
REQ-018 SHALL perform one shift-add (MUL) or restoring-subtract (DIV) step per ITER cycle, 32 cycles, counter 0..31; counter wrap from 31 moves to FIX.
REQ-019 SHALL, in FIX, apply two's-complement sign correction and write HI/LO, then go to DONE.
REQ-020 SHALL produce MUL as signed 64-bit product {c_hi_out, c_lo_out}; DIV as signed quotient in c_lo_out truncated toward zero, remainder in c_hi_out with sign of dividend.
REQ-021 SHALL, for DIV with b_in = 0, set c_lo_out = 0, c_hi_out = a_in, div_by_zero = 1.
REQ-022 SHALL, for illegal op, set c_lo_out = c_hi_out = 0, illegal_op = 1.
REQ-023 SHALL produce DIV 0x80000000 / 0xFFFFFFFF as quotient 0x80000000, remainder 0, no flag.
REQ-024 SHALL assert done for exactly the DONE cycle, then return to IDLE; latency acceptance-to-done = 1 cycle (EXEC path) or 34 cycles (LOAD path).
REQ-025 SHALL hold c_lo_out, c_hi_out and flags stable from done until the next acceptance; flags clear on acceptance.
REQ-026 SHALL ignore req_valid and operand changes while not IDLE; no request accepted during DONE.

Reset
REQ-027 SHALL, on clear = 0 at any time including mid-operation, enter IDLE asynchronously, drive done, c_lo_out, c_hi_out, div_by_zero, illegal_op to 0, counter to 0, abort any operation without completion pulse.
REQ-028 SHALL assert req_ready in the first cycle after clear deasserts.

Configuration
REQ-029 SHALL compile DIV support only when ALU_SEQUENCER_DIV_EN is defined.
REQ-030 SHALL, without ALU_SEQUENCER_DIV_EN, treat control 12 as illegal (EXEC path, illegal_op = 1, results 0) and never assert div_by_zero.

Verification
REQ-031 ADD a=5, b=7 -> done 1 cycle after acceptance, c_lo_out=0x0000000C, c_hi_out=0, flags 0.
REQ-032 MUL a=0xFFFFFFFF, b=3 -> done 34 cycles after acceptance, c_hi_out=0xFFFFFFFF, c_lo_out=0xFFFFFFFD.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> done at 34 cycles, c_lo_out=0xFFFFFFFD, c_hi_out=0xFFFFFFFF; DIV b=0, a=9 -> done at 1 cycle, c_hi_out=9, div_by_zero=1.
REQ-034 clear pulsed low 10 cycles into MUL -> outputs 0, no done pulse, req_ready=1 next cycle after release, next ADD 1+1 yields 2.
REQ-035 control=15 -> done at 1 cycle, illegal_op=1, results 0; back-to-back req_valid held high -> second acceptance only after DONE cycle.
REQ-036 build without ALU_SEQUENCER_DIV_EN, DIV a=10, b=2 -> done at 1 cycle, illegal_op=1, c_lo_out=0.
